// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    // Instruction substituted on an out-of-range fetch (addi x0, x0, 0).
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Clears the byte-offset bits of an address.
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    // Sequencer state encodings.
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HALTED  = 2'd1;
    localparam logic [1:0] ST_FAULTED = 2'd2;

    typedef enum logic [1:0] {
        RUN     = ST_RUN,
        HALTED  = ST_HALTED,
        FAULTED = ST_FAULTED
    } if_state_e;

    // One fetched instruction travelling toward decode.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } if_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order queue between fetch and decode. The head is a register,
// so the consumer never sees a combinational path from the push side.
module fetch_queue
    import if_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  if_entry_t entry_in,
    input  logic      pop,
    input  logic      flush,
    output if_entry_t head,
    output logic [1:0] count,
    output logic      full
);

    if_entry_t  head_q;
    if_entry_t  tail_q;
    logic [1:0] count_q;

    // Queue storage and occupancy; flush drops entries but leaves the head
    // register showing its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the entry registers are reset on purpose -- decode sees
            // the head directly and must read all-zero out of reset.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= entry_in;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, pop})
                        2'b10: begin
                            tail_q  <= entry_in;
                            count_q <= 2'd2;
                        end
                        2'b11:   head_q  <= entry_in;
                        2'b01:   count_q <= 2'd0;
                        default: ;
                    endcase
                end
                default: begin
                    // Full: a push is only offered together with a pop.
                    if (pop) begin
                        head_q <= tail_q;
                        if (push) begin
                            tail_q <= entry_in;
                        end else begin
                            count_q <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign head  = head_q;
    assign count = count_q;
    assign full  = (count_q == 2'd2);

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns the PC, drives the instruction memory address and
// feeds fetched words into a 2-entry queue toward decode.
module fetch_ctrl
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_fault
);

    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

    if_state_e  state_q;
    if_state_e  state_d;
    logic [31:0] pc_q;
    logic        fetch;
    logic        pop;
    logic        fault;
    logic        q_full;
    logic [1:0]  q_count;
    if_entry_t   push_entry;
    if_entry_t   head;

    assign pop   = out_valid && out_ready;
    assign fault = (pc_q >= MEM_BYTES);

    // Next-state and fetch decision; redirect overrides everything but reset.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        fetch   = 1'b0;
        if (redirect_valid) begin
            state_d = halt ? HALTED : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (halt) begin
                        state_d = HALTED;
                    end else if (!q_full || pop) begin
                        fetch = 1'b1;
                        if (fault) begin
                            state_d = FAULTED;
                        end
                    end
                end
                HALTED: begin
                    if (!halt) begin
                        state_d = RUN;
                    end
                end
                FAULTED: ;
                default: state_d = RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Program counter: redirect target, sequential advance, or hold on fault.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, independent of block ordering.
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= align_word(redirect_pc);
        end else if (fetch && !fault) begin
            pc_q <= pc_q + 32'd4;
        end
    end

    assign push_entry = '{pc: pc_q, instr: (fault ? NOP_INSTR : imem_instr), fault: fault};

    fetch_queue u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (fetch),
        .entry_in (push_entry),
        .pop      (pop),
        .flush    (redirect_valid),
        .head     (head),
        .count    (q_count),
        .full     (q_full)
    );

    assign imem_addr = pc_q;
    assign out_valid = (q_count != 2'd0);
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign out_fault = head.fault;

endmodule
